regfl_rd: RTL and testbench

- Reader/streamer for the 8x64 register file: takes the flattened 512-bit register-file output, snapshots it on a start command, and streams a programmable run of 64-bit words out over a valid/ready interface.
- Sits between the register file's block output and any downstream consumer (bus master, checker, serial link).
- Word order is fixed: word i = blk[64*i+63 : 64*i], so word 0 is the least significant 64 bits.

---
 rtl/regfl_rd.sv | 128 ++++++++++++
 tb/tb_regfl_rd.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/regfl_rd.sv
`default_nettype none
// ============================================================================
//  Module   : regfl_rd
//  Purpose  : Reader/streamer for an N x W register file. On a start command
//             in IDLE it snapshots the flattened block, then streams a run of
//             words (first index idx, length cnt, 0 meaning N) over a
//             valid/ready interface, wrapping the index modulo N.
//  Revision : 1.0  - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk    in   1       rising-edge clock
//    rst_b  in   1       asynchronous active-low reset
//    start  in   1       burst request, honoured only in IDLE
//    idx    in   AW      first word index of the burst
//    cnt    in   AW+1    number of words to send, 0 means N
//    blk    in   N*W     flattened register-file contents (word 0 = LSBs)
//    rdy    in   1       downstream ready
//    vld    out  1       q holds a valid word
//    q      out  W       current word
//    sel    out  AW      index of the word on q
//    busy   out  1       high while in SEND or DONE
//    done   out  1       one-cycle pulse after the last word is accepted
// ============================================================================
module regfl_rd #(
  parameter int W  = 64,
  parameter int N  = 8,
  parameter int AW = 3
) (
  input  logic              clk,
  input  logic              rst_b,
  input  logic              start,
  input  logic [AW-1:0]     idx,
  input  logic [AW:0]       cnt,
  input  logic [N*W-1:0]    blk,
  input  logic              rdy,
  output logic              vld,
  output logic [W-1:0]      q,
  output logic [AW-1:0]     sel,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [AW:0]   REM_FULL = (AW+1)'(N);
  localparam logic [AW:0]   REM_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] SEL_ONE  = AW'(1);

  state_t                 state_q, state_d;
  logic [N-1:0][W-1:0]    buf_q;
  logic [AW-1:0]          sel_q, sel_d;
  logic [AW:0]            rem_q, rem_d;
  logic                   load;
  logic                   vld_q, busy_q, done_q;

  // Next-state and datapath control.
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    rem_d   = rem_q;
    load    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          load    = 1'b1;
          sel_d   = idx;
          rem_d   = (cnt == '0) ? REM_FULL : cnt;
          state_d = SEND;
        end
      end
      SEND: begin
        // vld_q is high throughout SEND, so the handshake reduces to rdy.
        if (rdy) begin
          if (rem_q == REM_ONE) begin
            rem_d   = '0;
            state_d = DONE;
          end else begin
            sel_d = sel_q + SEL_ONE;  // wraps naturally since N = 2**AW
            rem_d = rem_q - REM_ONE;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, snapshot and registered status outputs. The status flags are
  // registered from the next state so they line up with the state register.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q <= IDLE;
      buf_q   <= '0;
      sel_q   <= '0;
      rem_q   <= '0;
      vld_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      rem_q   <= rem_d;
      if (load) begin
        buf_q <= blk;
      end
      vld_q  <= (state_d == SEND);
      busy_q <= (state_d != IDLE);
      done_q <= (state_d == DONE);
    end
  end

  // q is a mux of registered data by a registered index; no input reaches it.
  assign q    = buf_q[sel_q];
  assign sel  = sel_q;
  assign vld  = vld_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule
`default_nettype wire

// File: tb/tb_regfl_rd.sv
`default_nettype none
// ============================================================================
//  Module   : tb_regfl_rd
//  Purpose  : Directed self-checking bench for regfl_rd. Word i of the block
//             is 64'hA000 + i, so every expected q is derived from its sel.
//  Revision : 1.0  - initial release
// ============================================================================
module tb_regfl_rd;

  localparam int W  = 64;
  localparam int N  = 8;
  localparam int AW = 3;

  logic              clk;
  logic              rst_b;
  logic              start;
  logic [AW-1:0]     idx;
  logic [AW:0]       cnt;
  logic [N*W-1:0]    blk;
  logic              rdy;
  logic              vld;
  logic [W-1:0]      q;
  logic [AW-1:0]     sel;
  logic              busy;
  logic              done;

  logic [N*W-1:0]    pat;
  int                n_checks;
  int                n_pass;

  regfl_rd #(.W(W), .N(N), .AW(AW)) dut (
    .clk   (clk),
    .rst_b (rst_b),
    .start (start),
    .idx   (idx),
    .cnt   (cnt),
    .blk   (blk),
    .rdy   (rdy),
    .vld   (vld),
    .q     (q),
    .sel   (sel),
    .busy  (busy),
    .done  (done)
  );

  // Rising edges at 10, 20, 30 ...; falling edges at 5, 15, 25 ...
  initial begin
    clk = 1'b1;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic logic [63:0] word_of(input int i);
    return 64'hA000 + 64'(i % N);
  endfunction

  // Called at a falling edge; raises start for one rising edge and returns at
  // the following falling edge, where the first word must already be on q.
  task automatic do_start(input int first, input int len);
    start = 1'b1;
    idx   = AW'(first);
    cnt   = (AW+1)'(len);
    @(negedge clk);
    start = 1'b0;
  endtask

  // With rdy=1, expects len words starting at index first, then one done cycle.
  task automatic stream(input string tag, input int first, input int len);
    for (int k = 0; k < len; k++) begin
      check($sformatf("%s vld[%0d]", tag, k), 64'(vld), 64'd1);
      check($sformatf("%s busy[%0d]", tag, k), 64'(busy), 64'd1);
      check($sformatf("%s done[%0d]", tag, k), 64'(done), 64'd0);
      check($sformatf("%s sel[%0d]", tag, k), 64'(sel), 64'((first + k) % N));
      check($sformatf("%s q[%0d]", tag, k), q, word_of(first + k));
      @(negedge clk);
    end
    check({tag, " done pulse"}, 64'(done), 64'd1);
    check({tag, " busy in DONE"}, 64'(busy), 64'd1);
    check({tag, " vld in DONE"}, 64'(vld), 64'd0);
    @(negedge clk);
    check({tag, " done cleared"}, 64'(done), 64'd0);
    check({tag, " busy cleared"}, 64'(busy), 64'd0);
    check({tag, " vld idle"}, 64'(vld), 64'd0);
  endtask

  initial begin
    logic [63:0] got_q[$];

    n_checks = 0;
    n_pass   = 0;
    for (int i = 0; i < N; i++) pat[64*i +: 64] = 64'hA000 + 64'(i);
    rst_b = 1'b0;
    start = 1'b0;
    idx   = '0;
    cnt   = '0;
    blk   = pat;
    rdy   = 1'b1;

    // Reset state, and no activity without start.
    #25 rst_b = 1'b1;
    repeat (3) @(negedge clk);
    check("rst vld", 64'(vld), 64'd0);
    check("rst q", q, 64'd0);
    check("rst sel", 64'(sel), 64'd0);
    check("rst busy", 64'(busy), 64'd0);
    check("rst done", 64'(done), 64'd0);

    // Full burst, cnt=0 means all 8 words from idx 0.
    do_start(0, 0);
    stream("full", 0, 8);

    // Wrap-around 6,7,0,1.
    do_start(6, 4);
    stream("wrap", 6, 4);

    // Backpressure: rdy low for 3 cycles, then toggling.
    rdy = 1'b0;
    do_start(2, 3);
    for (int k = 0; k < 3; k++) begin
      check($sformatf("bp hold vld[%0d]", k), 64'(vld), 64'd1);
      check($sformatf("bp hold sel[%0d]", k), 64'(sel), 64'd2);
      check($sformatf("bp hold q[%0d]", k), q, 64'hA002);
      @(negedge clk);
    end
    got_q.delete();
    for (int k = 0; k < 20; k++) begin
      rdy = (k % 2 == 0);
      if (vld && rdy) got_q.push_back(q);
      @(negedge clk);
      if (got_q.size() == 3) break;
    end
    rdy = 1'b1;
    check("bp word count", 64'(got_q.size()), 64'd3);
    check("bp done pulse", 64'(done), 64'd1);
    for (int k = 0; k < 3; k++) begin
      if (k < got_q.size()) check($sformatf("bp word[%0d]", k), got_q[k], word_of(2 + k));
    end
    @(negedge clk);
    check("bp done cleared", 64'(done), 64'd0);

    // Snapshot holds and a start during SEND is ignored.
    do_start(0, 4);
    check("snap q0", q, 64'hA000);
    blk   = '1;
    start = 1'b1;
    idx   = 3'd5;
    cnt   = 4'd1;
    @(negedge clk);
    start = 1'b0;
    check("snap sel1", 64'(sel), 64'd1);
    check("snap q1", q, 64'hA001);
    @(negedge clk);
    check("snap q2", q, 64'hA002);
    @(negedge clk);
    check("snap sel3", 64'(sel), 64'd3);
    check("snap q3", q, 64'hA003);
    @(negedge clk);
    check("snap done", 64'(done), 64'd1);
    repeat (2) @(negedge clk);
    check("snap no restart vld", 64'(vld), 64'd0);
    check("snap no restart busy", 64'(busy), 64'd0);
    blk = pat;

    // Reset mid-burst after two accepted words.
    do_start(0, 0);
    @(negedge clk);
    @(negedge clk);
    check("mid sel before rst", 64'(sel), 64'd2);
    #2 rst_b = 1'b0;
    #1;
    check("mid rst vld", 64'(vld), 64'd0);
    check("mid rst busy", 64'(busy), 64'd0);
    check("mid rst q", q, 64'd0);
    check("mid rst sel", 64'(sel), 64'd0);
    @(negedge clk);
    check("mid rst no done", 64'(done), 64'd0);
    rst_b = 1'b1;
    @(negedge clk);
    check("mid post rst done", 64'(done), 64'd0);
    do_start(3, 2);
    stream("after rst", 3, 2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
